baud_gen_frac: RTL and testbench
================================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter CNT_W, default 16: width of the integer divisor and the cycle counter.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor and the phase accumulator.
REQ-003 Parameter OVERSAMPLE, default 16: number of o_tick pulses per o_bit_tick pulse; legal range 2..256.
REQ-004 Parameter DEFAULT_INT, default 325: integer divisor loaded at reset.
REQ-005 Parameter DEFAULT_FRAC, default 8: fractional divisor loaded at reset; 325 + 8/16 = 325.5 gives 19200 baud x16 from 100 MHz.
REQ-006 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port i_reset, input, 1: asynchronous, active-high reset.
REQ-008 Port i_en, input, 1: run enable.
REQ-009 Port i_div_wr, input, 1: one-cycle strobe that captures i_div_int and i_div_frac.
REQ-010 Port i_div_int, input, CNT_W: requested integer divisor.
REQ-011 Port i_div_frac, input, FRAC_W: requested fractional divisor in units of 2^-FRAC_W.
REQ-012 Port o_tick, output, 1: registered one-cycle oversample tick.
REQ-013 Port o_bit_tick, output, 1: registered one-cycle bit tick, coincident with every OVERSAMPLE-th o_tick.
REQ-014 Port o_div_pending, output, 1: high while a captured divisor is waiting to be applied.

Function
REQ-015 The block SHALL hold active registers div_int/div_frac, shadow registers, a CNT_W cycle counter cnt, a FRAC_W accumulator acc, a 1-bit extra flag and a sub-tick counter sub.
REQ-016 An effective integer divisor below 2 (on the port or in a parameter) SHALL be treated as 2.
REQ-017 Period limit lim SHALL equal div_int - 1 + extra; while i_en=1, cnt==lim -> cnt<=0 and o_tick<=1, otherwise cnt<=cnt+1 and o_tick<=0.
REQ-018 On each wrap, {carry, acc} <= acc + div_frac in FRAC_W+1 bits and extra <= carry, so period = div_int + extra cycles.
REQ-019 Average period SHALL be div_int + div_frac/2^FRAC_W cycles; with div_frac=0, every period SHALL be exactly div_int cycles.
REQ-020 sub SHALL increment on each wrap and return to 0 after OVERSAMPLE-1; o_bit_tick<=1 on the wrap where sub==OVERSAMPLE-1, otherwise 0.
REQ-021 i_div_wr=1 SHALL load the shadow registers and set o_div_pending=1 on the next edge.
REQ-022 A second i_div_wr while pending SHALL overwrite the shadow registers (last write wins).
REQ-023 While i_en=1 with pending set, the shadow SHALL be copied to active on the next wrap edge, together with acc<=0, extra<=0 and o_div_pending<=0; the period following that tick SHALL use the new divisor.
REQ-024 i_div_wr and an apply in the same cycle: the applied value SHALL be the old shadow, the new write SHALL be captured, and o_div_pending SHALL remain 1.
REQ-025 While i_en=0, cnt, acc, extra and sub SHALL be held at 0 and o_tick=o_bit_tick=0; a pending divisor SHALL be applied on the first i_en=0 cycle.
REQ-026 On the 0->1 transition of i_en, the first o_tick SHALL assert div_int cycles after the first enabled edge.

Reset
REQ-027 i_reset=1 SHALL immediately force cnt=0, acc=0, extra=0, sub=0, o_tick=0, o_bit_tick=0, o_div_pending=0, div_int=DEFAULT_INT, div_frac=DEFAULT_FRAC and shadow=defaults.
REQ-028 Reset asserted mid-period or with a pending update SHALL discard all progress and the pending value; operation SHALL resume from REQ-026 after release.

Verification
REQ-029 Reset then i_en=1 with default parameters -> o_tick periods 325,325,326,325,326,...; 1000 consecutive periods average 325.5 +/- 0.001.
REQ-030 Write int=4 frac=0 with i_en=0, then enable -> o_tick every 4 cycles; o_bit_tick on every 16th o_tick; o_div_pending low 1 cycle after the write.
REQ-031 Write int=3 frac=8 (FRAC_W=4) -> periods 3,3,4,3,4,...; no two consecutive 4-cycle periods.
REQ-032 While running at int=10, write int=5 at cnt=3 -> remaining period still 10 cycles; following periods 5; o_div_pending falls at that tick.
REQ-033 Write int=0 then int=1 -> both behave as 2 (o_tick every 2 cycles); write coinciding with a wrap follows REQ-024.
REQ-034 Assert i_reset for 1 cycle mid-period with a write pending -> outputs 0 immediately; defaults restored; o_div_pending=0; first tick 325 cycles after release.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: emits an oversample tick every
// div_int + div_frac/2^FRAC_W cycles on average and a bit tick every
// OVERSAMPLE-th oversample tick. Divisor updates go through a shadow
// register and take effect on a period boundary.
module baud_gen_frac #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FRAC_W       = 4,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DEFAULT_INT  = 325,
  parameter int unsigned DEFAULT_FRAC = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_div_wr,
  input  logic [CNT_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  output logic              o_tick,
  output logic              o_bit_tick,
  output logic              o_div_pending
);

  localparam int unsigned SUB_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0]  DEF_INT  = (DEFAULT_INT < 2) ? CNT_W'(2) : CNT_W'(DEFAULT_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_FRAC);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVERSAMPLE - 1);

  // Integer divisors below 2 cannot produce a one-cycle pulse train.
  function automatic logic [CNT_W-1:0] clamp_int(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  logic [CNT_W-1:0]  div_int_q,  div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [CNT_W-1:0]  sh_int_q,   sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q,  sh_frac_d;
  logic              pend_q,     pend_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [FRAC_W-1:0] acc_q,      acc_d;
  logic              extra_q,    extra_d;
  logic [SUB_W-1:0]  sub_q,      sub_d;
  logic              tick_q,     tick_d;
  logic              bit_q,      bit_d;

  logic [CNT_W-1:0]  lim;
  logic              wrap;
  logic [FRAC_W:0]   frac_sum;
  logic              apply;

  // Period limit stretches by one cycle whenever the phase accumulator carried.
  always_comb begin
    lim      = div_int_q - CNT_W'(1) + {{(CNT_W-1){1'b0}}, extra_q};
    wrap     = (cnt_q == lim);
    frac_sum = {1'b0, acc_q} + {1'b0, div_frac_q};
  end

  // Next-state: counting, fractional phase, sub-tick, shadow capture/apply.
  always_comb begin
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    extra_d    = extra_q;
    sub_d      = sub_q;
    tick_d     = 1'b0;
    bit_d      = 1'b0;
    apply      = 1'b0;

    if (i_en) begin
      if (wrap) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        acc_d   = frac_sum[FRAC_W-1:0];
        extra_d = frac_sum[FRAC_W];
        bit_d   = (sub_q == SUB_LAST);
        sub_d   = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
        apply   = pend_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      sub_d   = '0;
      apply   = pend_q;
    end

    // A new divisor restarts the fractional phase so its first period is exact.
    if (apply) begin
      div_int_d  = sh_int_q;
      div_frac_d = sh_frac_q;
      acc_d      = '0;
      extra_d    = 1'b0;
      pend_d     = 1'b0;
    end

    // A write in the same cycle as an apply is kept for the next boundary.
    if (i_div_wr) begin
      sh_int_d  = clamp_int(i_div_int);
      sh_frac_d = i_div_frac;
      pend_d    = 1'b1;
    end
  end

  // State registers with asynchronous reset to the default divisor.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_int_q  <= DEF_INT;
      div_frac_q <= DEF_FRAC;
      sh_int_q   <= DEF_INT;
      sh_frac_q  <= DEF_FRAC;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      extra_q    <= 1'b0;
      sub_q      <= '0;
      tick_q     <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      extra_q    <= extra_d;
      sub_q      <= sub_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
    end
  end

  assign o_tick        = tick_q;
  assign o_bit_tick    = bit_q;
  assign o_div_pending = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios plus random traffic, all
// checked every cycle against a period-level reference model.
module tb_baud_gen_frac;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FRAC_W = 4;
  localparam int          OS     = 16;
  localparam int          SCALE  = 16;
  localparam int          D_INT  = 325;
  localparam int          D_FRAC = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic              wr  = 1'b0;
  logic [CNT_W-1:0]  dint = '0;
  logic [FRAC_W-1:0] dfrac = '0;
  logic              tick, bit_tick, pending;

  int checks = 0;
  int errors = 0;

  // Reference model: period n after a restart lasts int + floor((n-1)f/S) - floor((n-2)f/S).
  int m_int, m_frac, m_sh_int, m_sh_frac, m_pend, m_n, m_el, m_sub;
  int e_tick, e_bit;

  baud_gen_frac #(
    .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
    .DEFAULT_INT(D_INT), .DEFAULT_FRAC(D_FRAC)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_div_wr(wr),
    .i_div_int(dint), .i_div_frac(dfrac),
    .o_tick(tick), .o_bit_tick(bit_tick), .o_div_pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int plen(input int n);
    if (n <= 1) return m_int;
    return m_int + ((n - 1) * m_frac) / SCALE - ((n - 2) * m_frac) / SCALE;
  endfunction

  task automatic model_reset();
    m_int = D_INT; m_frac = D_FRAC; m_sh_int = D_INT; m_sh_frac = D_FRAC;
    m_pend = 0; m_n = 1; m_el = 0; m_sub = 0; e_tick = 0; e_bit = 0;
  endtask

  task automatic model_edge(input int a_en, input int a_wr, input int a_di, input int a_df);
    int ap;
    ap = 0; e_tick = 0; e_bit = 0;
    if (a_en != 0) begin
      m_el++;
      if (m_el >= plen(m_n)) begin
        e_tick = 1;
        e_bit  = (m_sub == OS - 1) ? 1 : 0;
        m_sub  = (m_sub == OS - 1) ? 0 : m_sub + 1;
        m_n++;
        m_el = 0;
        ap = m_pend;
      end
    end else begin
      m_el = 0; m_n = 1; m_sub = 0; ap = m_pend;
    end
    if (ap != 0) begin
      m_int = m_sh_int; m_frac = m_sh_frac; m_n = 1; m_pend = 0;
    end
    if (a_wr != 0) begin
      m_sh_int = clampi(a_di); m_sh_frac = a_df; m_pend = 1;
    end
  endtask

  // One clock: drive inputs now, advance model on the edge, compare 1 time unit later.
  task automatic step(input int a_en, input int a_wr, input int a_di, input int a_df);
    en = (a_en != 0); wr = (a_wr != 0);
    dint = CNT_W'(a_di); dfrac = FRAC_W'(a_df);
    @(posedge clk);
    model_edge(a_en, a_wr, a_di, a_df);
    #1;
    chk("tick", tick, e_tick);
    chk("bit_tick", bit_tick, e_bit);
    chk("pending", pending, m_pend);
  endtask

  // Run enabled until the next o_tick; n = cycles taken.
  task automatic run_to_tick(output int n);
    n = 0;
    do begin
      step(1, 0, 0, 0);
      n++;
    end while (!tick && n < 2000);
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic do_reset();
    #2;
    wr  = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_bit", bit_tick, 0);
    chk("rst_pending", pending, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, sum, prev, consec, bits, ok;
    int exp_seq[5];
    int r_en;

    model_reset();
    #1;
    chk("rst0_tick", tick, 0);
    chk("rst0_bit", bit_tick, 0);
    chk("rst0_pending", pending, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Default divisor 325.5: periods 325,325,326,325,326.
    exp_seq = '{325, 325, 326, 325, 326};
    for (int i = 0; i < 5; i++) begin
      run_to_tick(n);
      chk($sformatf("def_period%0d", i), n, exp_seq[i]);
    end

    // Integer divisor 4 written while disabled.
    step(0, 0, 0, 0);
    step(0, 1, 4, 0);
    chk("wr_pending_set", pending, 1);
    step(0, 0, 0, 0);
    chk("wr_pending_clr", pending, 0);
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      run_to_tick(n);
      chk("int4_period", n, 4);
      if (bit_tick) bits++;
    end
    chk("int4_bit_count", bits, 2);

    // 3 + 8/16: 3,3,4,3,4 and 1000-period average.
    step(1, 1, 3, 8);
    n = 0;
    do begin
      run_to_tick(prev);
      n++;
    end while (pending && n < 10);
    chk("f38_applied", pending, 0);
    exp_seq = '{3, 3, 4, 3, 4};
    sum = 0; consec = 0; prev = 0;
    for (int i = 0; i < 1000; i++) begin
      run_to_tick(n);
      if (i < 5) chk($sformatf("f38_period%0d", i), n, exp_seq[i]);
      if (n == 4 && prev == 4) consec++;
      prev = n;
      sum += n;
    end
    ok = (sum >= 3499 && sum <= 3501) ? 1 : 0;
    chk("f38_avg", ok, 1);
    chk("f38_no_double4", consec, 0);

    // Mid-period write: old period finishes, new one follows.
    step(1, 1, 10, 0);
    n = 0;
    do begin
      run_to_tick(prev);
      n++;
    end while (pending && n < 10);
    run_to_tick(n);
    chk("int10_period", n, 10);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 5, 0);
    run_to_tick(n);
    chk("int10_remaining", n, 6);
    chk("int10_pend_fall", pending, 0);
    run_to_tick(n);
    chk("int5_period", n, 5);

    // Divisors 0 and 1 clamp to 2.
    step(1, 1, 0, 0);
    run_to_tick(n);
    run_to_tick(n);
    chk("int0_period", n, 2);
    step(1, 1, 1, 0);
    run_to_tick(n);
    run_to_tick(n);
    chk("int1_period", n, 2);

    // Write on the same edge as an apply: old shadow applied, new one stays pending.
    step(1, 1, 7, 0);
    n = 0;
    while (!(m_pend != 0 && m_el + 1 == plen(m_n)) && n < 20) begin
      step(1, 0, 0, 0);
      n++;
    end
    step(1, 1, 9, 0);
    chk("coinc_tick", tick, 1);
    chk("coinc_pending", pending, 1);
    run_to_tick(n);
    chk("coinc_old_applied", n, 7);
    chk("coinc_pend_clr", pending, 0);
    run_to_tick(n);
    chk("coinc_new_applied", n, 9);

    // Random traffic checked cycle by cycle.
    r_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) r_en = 1 - r_en;
      if ($urandom_range(0, 39) == 0)
        step(r_en, 1, $urandom_range(0, 12), $urandom_range(0, 15));
      else
        step(r_en, 0, 0, 0);
    end

    // Reset mid-period with a pending write.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 6, 3);
    do_reset();
    chk("post_rst_pending", pending, 0);
    exp_seq = '{325, 325, 326, 325, 326};
    for (int i = 0; i < 3; i++) begin
      run_to_tick(n);
      chk($sformatf("post_rst_period%0d", i), n, exp_seq[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
